romem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-ported instruction read-only memory (`romem`) between two requesters, e.g. the DLX fetch stage (port 0) and the debug/boot loader (port 1). It sequences each memory read on the `mem_interface` handshake (ENABLE/ADDRESS out, DATA/DATA_READY in), returns the word to the owning port with a one-cycle valid pulse, and optionally aborts reads that never complete.

---
 rtl/romem_arbiter.sv | 124 ++++++++++++
 tb/tb_romem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/romem_arbiter.sv
// Round-robin arbiter sharing the instruction ROM between two read ports.
// Optional BUSY-cycle watchdog enabled by defining ROM_ARB_TIMEOUT_EN.
module romem_arbiter #(
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned ADDRESS_SIZE   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    REQ0,
  input  logic                    REQ1,
  input  logic [ADDRESS_SIZE-1:0] ADDR0,
  input  logic [ADDRESS_SIZE-1:0] ADDR1,
  output logic                    GNT0,
  output logic                    GNT1,
  output logic [WORD_SIZE-1:0]    RDATA0,
  output logic [WORD_SIZE-1:0]    RDATA1,
  output logic                    RVALID0,
  output logic                    RVALID1,
  output logic                    ERROR,
  output logic                    MEM_ENABLE,
  output logic [ADDRESS_SIZE-1:0] MEM_ADDRESS,
  input  logic [WORD_SIZE-1:0]    MEM_DATA,
  input  logic                    MEM_DATA_READY
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t               state;
  logic                 last_gnt;   // also identifies the owner of the read in flight
  logic                 first_busy;
  logic                 want0;
  logic                 want1;
  logic                 ready_ok;
  logic                 timeout;
  logic                 done;
  logic [WORD_SIZE-1:0] resp_data;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  assign want0 = REQ0 & (~REQ1 | last_gnt);
  assign want1 = REQ1 & (~REQ0 | ~last_gnt);

  // The memory keeps ready high one cycle after ENABLE drops; skip it on BUSY entry.
  assign ready_ok  = MEM_DATA_READY & ~first_busy;
  assign done      = ready_ok | timeout;
  assign resp_data = ready_ok ? MEM_DATA : '0;

`ifdef ROM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] busy_cnt;
  assign timeout = (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_gnt    <= 1'b1;
      first_busy  <= 1'b0;
      GNT0        <= 1'b0;
      GNT1        <= 1'b0;
      RVALID0     <= 1'b0;
      RVALID1     <= 1'b0;
      ERROR       <= 1'b0;
      MEM_ENABLE  <= 1'b0;
      MEM_ADDRESS <= '0;
      RDATA0      <= '0;
      RDATA1      <= '0;
`ifdef ROM_ARB_TIMEOUT_EN
      busy_cnt    <= '0;
`endif
    end else begin
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      RVALID0 <= 1'b0;
      RVALID1 <= 1'b0;
      ERROR   <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (want0 | want1) begin
            last_gnt    <= want1;
            MEM_ADDRESS <= want1 ? ADDR1 : ADDR0;
            GNT0        <= want0;
            GNT1        <= want1;
            MEM_ENABLE  <= 1'b1;
            first_busy  <= 1'b1;
`ifdef ROM_ARB_TIMEOUT_EN
            busy_cnt    <= '0;
`endif
            state       <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          first_busy <= 1'b0;
          if (done) begin
            MEM_ENABLE <= 1'b0;
            ERROR      <= ~ready_ok;
            if (last_gnt) begin
              RDATA1  <= resp_data;
              RVALID1 <= 1'b1;
            end else begin
              RDATA0  <= resp_data;
              RVALID0 <= 1'b1;
            end
            state <= RESP;
          end
`ifdef ROM_ARB_TIMEOUT_EN
          else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_romem_arbiter.sv
// Scoreboard bench for romem_arbiter: directed requests, queued expectations,
// a negedge monitor pops and compares every grant and every response.
module tb_romem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        REQ0, REQ1;
  logic [15:0] ADDR0, ADDR1;
  logic        GNT0, GNT1, RVALID0, RVALID1, ERROR, MEM_ENABLE;
  logic [31:0] RDATA0, RDATA1;
  logic [15:0] MEM_ADDRESS;
  logic [31:0] MEM_DATA;
  logic        MEM_DATA_READY;

  romem_arbiter #(.WORD_SIZE(32), .ADDRESS_SIZE(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1),
    .GNT0(GNT0), .GNT1(GNT1), .RDATA0(RDATA0), .RDATA1(RDATA1),
    .RVALID0(RVALID0), .RVALID1(RVALID1), .ERROR(ERROR),
    .MEM_ENABLE(MEM_ENABLE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_DATA(MEM_DATA), .MEM_DATA_READY(MEM_DATA_READY)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: registered ready follows ENABLE, so ready lingers one cycle after ENABLE falls.
  logic        mem_rdy_q = 1'b0;
  logic [31:0] mem_q = '0;
  logic        force_hi = 1'b0;
  logic        kill = 1'b0;

  function automatic logic [31:0] rom(input logic [15:0] a);
    return 32'h2001_0000 | {16'h0000, a + 16'd1};
  endfunction

  always @(posedge clk) begin
    mem_rdy_q <= MEM_ENABLE;
    mem_q     <= rom(MEM_ADDRESS);
  end
  assign MEM_DATA_READY = force_hi | (mem_rdy_q & ~kill);
  assign MEM_DATA = force_hi ? 32'hDEAD_BEEF : (MEM_DATA_READY ? mem_q : 'z);

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
    int unsigned lat;
  } resp_t;

  resp_t exp_r[$];
  bit    exp_g[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int unsigned gnt_cyc[2];
  int unsigned prev_g = 0;
  bit          prev_v = 1'b0;
  bit          streaming = 1'b0;
  int unsigned n_gnt = 0;
  int unsigned n_rv = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (GNT0 || GNT1) begin
        n_gnt++;
        check("gnt_onehot", {63'd0, GNT0 & GNT1}, 64'd0);
        check("gnt_pending", {63'd0, exp_g.size() != 0}, 64'd1);
        if (exp_g.size() != 0) check("gnt_port", {63'd0, GNT1}, {63'd0, exp_g.pop_front()});
        gnt_cyc[GNT1] = cyc;
        if (streaming && prev_v) check("gnt_spacing", 64'(cyc - prev_g), 64'd3);
        prev_g = cyc;
        prev_v = 1'b1;
      end
      if (RVALID0 || RVALID1) begin
        resp_t e;
        n_rv++;
        check("rvalid_onehot", {63'd0, RVALID0 & RVALID1}, 64'd0);
        check("rvalid_pending", {63'd0, exp_r.size() != 0}, 64'd1);
        if (exp_r.size() != 0) begin
          e = exp_r.pop_front();
          check("rvalid_port", {63'd0, RVALID1}, {63'd0, e.port});
          check("rdata", {32'd0, RVALID1 ? RDATA1 : RDATA0}, {32'd0, e.data});
          check("error", {63'd0, ERROR}, {63'd0, e.err});
          check("latency", 64'(cyc - gnt_cyc[e.port]), 64'(e.lat));
        end
      end else if (ERROR) begin
        check("error_alone", {63'd0, ERROR}, 64'd0);
      end
    end
  end

  task automatic wait_gnt(input bit port);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      #1;
      got = port ? GNT1 : GNT0;
    end
    check("gnt_wait", {63'd0, got}, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_r.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_resp", 64'(exp_r.size()), 64'd0);
    check("drain_gnt", 64'(exp_g.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a1_tbl[3];
    logic [31:0] d1_tbl[3];
    int unsigned start, rv_before;
    a1_tbl = '{16'h0100, 16'h0200, 16'h0300};
    d1_tbl = '{32'h2001_0101, 32'h2001_0201, 32'h2001_0301};

    rst = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; ADDR0 = '0; ADDR1 = '0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {58'd0, GNT0, GNT1, RVALID0, RVALID1, ERROR, MEM_ENABLE}, 64'd0);
    check("rst_addr", {48'd0, MEM_ADDRESS}, 64'd0);
    check("rst_rdata", {RDATA1, RDATA0}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single port-0 read
    exp_g.push_back(1'b0);
    exp_r.push_back(resp_t'{1'b0, 32'h2001_0005, 1'b0, 2});
    REQ0 = 1'b1; ADDR0 = 16'h0004;
    @(negedge clk);
    check("t1_gnt0", {63'd0, GNT0}, 64'd1);
    check("t1_mem_en", {63'd0, MEM_ENABLE}, 64'd1);
    check("t1_mem_addr", {48'd0, MEM_ADDRESS}, 64'h0004);
    REQ0 = 1'b0;
    @(negedge clk);
    check("t1_rvalid_early", {63'd0, RVALID0}, 64'd0);
    @(negedge clk);
    check("t1_rvalid0", {63'd0, RVALID0}, 64'd1);
    check("t1_port1_quiet", {62'd0, GNT1, RVALID1}, 64'd0);
    drain();
    repeat (2) @(negedge clk);

    // Port 1 alone, three back-to-back requests
    prev_v = 1'b0; streaming = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_g.push_back(1'b1);
      exp_r.push_back(resp_t'{1'b1, d1_tbl[i], 1'b0, 2});
    end
    REQ1 = 1'b1; ADDR1 = a1_tbl[0];
    for (int i = 0; i < 3; i++) begin
      wait_gnt(1'b1);
      if (i < 2) ADDR1 = a1_tbl[i+1];
    end
    REQ1 = 1'b0; streaming = 1'b0;
    drain();
    repeat (2) @(negedge clk);

    // Both ports held: alternating grants starting with port 0
    prev_v = 1'b0; streaming = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_g.push_back(1'b0); exp_r.push_back(resp_t'{1'b0, 32'h2001_0011, 1'b0, 2});
      exp_g.push_back(1'b1); exp_r.push_back(resp_t'{1'b1, 32'h2001_0021, 1'b0, 2});
    end
    start = n_gnt;
    REQ0 = 1'b1; ADDR0 = 16'h0010; REQ1 = 1'b1; ADDR1 = 16'h0020;
    for (int i = 0; i < 30 && n_gnt < start + 4; i++) begin
      @(negedge clk);
      #1;
    end
    REQ0 = 1'b0; REQ1 = 1'b0; streaming = 1'b0;
    check("t2_grant_count", 64'(n_gnt - start), 64'd4);
    drain();
    repeat (2) @(negedge clk);

    // Reset asserted during BUSY drops the read
    exp_g.push_back(1'b0);
    REQ0 = 1'b1; ADDR0 = 16'h0030;
    wait_gnt(1'b0);
    REQ0 = 1'b0;
    rv_before = n_rv;
    rst = 1'b0;
    #1;
    check("t4_rst_ctrl", {58'd0, GNT0, GNT1, RVALID0, RVALID1, ERROR, MEM_ENABLE}, 64'd0);
    check("t4_rst_addr", {48'd0, MEM_ADDRESS}, 64'd0);
    check("t4_rst_rdata", {RDATA1, RDATA0}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("t4_no_rvalid", 64'(n_rv), 64'(rv_before));
    exp_g.push_back(1'b0);
    exp_r.push_back(resp_t'{1'b0, 32'h2001_0041, 1'b0, 2});
    REQ0 = 1'b1; ADDR0 = 16'h0040;
    wait_gnt(1'b0);
    REQ0 = 1'b0;
    drain();
    repeat (2) @(negedge clk);

    // Ready held high with no request
    rv_before = n_rv;
    force_hi = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_idle_en", {63'd0, MEM_ENABLE}, 64'd0);
    end
    force_hi = 1'b0;
    check("t6_no_rvalid", 64'(n_rv), 64'(rv_before));
    check("t6_rdata0_held", {32'd0, RDATA0}, 64'h2001_0041);
    repeat (2) @(negedge clk);

`ifdef ROM_ARB_TIMEOUT_EN
    // Memory never answers: read aborts with ERROR after 8 BUSY cycles
    kill = 1'b1;
    exp_g.push_back(1'b0);
    exp_r.push_back(resp_t'{1'b0, 32'h0000_0000, 1'b1, 8});
    REQ0 = 1'b1; ADDR0 = 16'h0050;
    wait_gnt(1'b0);
    REQ0 = 1'b0;
    drain();
    kill = 1'b0;
    check("t5_rdata0_zero", {32'd0, RDATA0}, 64'd0);
    repeat (2) @(negedge clk);
    check("t5_back_idle", {63'd0, MEM_ENABLE}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
